// File: rtl/pipelined_array_multiplier.sv
`default_nettype none
// ============================================================================
//  Module   : pipelined_array_multiplier
//  Purpose  : WIDTH x WIDTH array multiplier. The partial-product rows are
//             split across STAGES register stages. Unsigned operands use the
//             plain array. Signed operands use the Baugh-Wooley array. Every
//             stage carries its own valid bit, mode and operands, so unsigned
//             and signed operations can be in flight at the same time. A
//             single advance condition stalls the whole pipe when the result
//             at the output has not been taken.
//  Ports    : clk94          - clock, rising edge
//             rst94          - synchronous active-high reset
//             start94        - operand valid (transfer when ready94=1)
//             signed94       - 1 = two's complement operands
//             multiplier94   - operand A
//             multiplicand94 - operand B
//             ready94        - a transfer can be accepted this cycle
//             done94         - product94 holds an undelivered result
//             ack94          - consumer takes the result
//             product94      - 2*WIDTH result (or accumulator)
//             acc_clr94      - (MULT_ACCUM_EN) load rather than add
//             overflow94     - (MULT_ACCUM_EN) sticky accumulate overflow
//  Options  : define MULT_ACCUM_EN to turn product94 into an accumulator.
//  Revision : 1.0 - initial release
// ============================================================================
module pipelined_array_multiplier #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic               clk94,
  input  logic               rst94,
  input  logic               start94,
  input  logic               signed94,
  input  logic [WIDTH-1:0]   multiplier94,
  input  logic [WIDTH-1:0]   multiplicand94,
`ifdef MULT_ACCUM_EN
  input  logic               acc_clr94,
  output logic               overflow94,
`endif
  output logic               ready94,
  output logic               done94,
  input  logic               ack94,
  output logic [2*WIDTH-1:0] product94
);

  localparam int PW   = 2 * WIDTH;
  localparam int ROWS = (WIDTH + STAGES - 1) / STAGES;
  localparam logic [PW-1:0] ONE = {{(PW-1){1'b0}}, 1'b1};
  // Baugh-Wooley correction constant: 2^WIDTH + 2^(2*WIDTH-1)
  localparam logic [PW-1:0] BW_CONST = (ONE << WIDTH) | (ONE << (PW - 1));

  // Sum of partial-product rows lo..hi-1. Row i is multiplier bit i ANDed with
  // the multiplicand. In signed mode the cross terms that involve exactly one
  // sign bit are inverted.
  function automatic logic [PW-1:0] rows_sum(
    input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] b,
    input logic             sgn,
    input int               lo,
    input int               hi
  );
    logic [PW-1:0] acc;
    logic          pp;
    acc = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (i >= lo && i < hi) begin
        for (int j = 0; j < WIDTH; j++) begin
          pp = a[i] & b[j];
          if (sgn && ((i == WIDTH - 1) != (j == WIDTH - 1))) pp = ~pp;
          acc = acc + ({{(PW-1){1'b0}}, pp} << (i + j));
        end
      end
    end
    return acc;
  endfunction

  // Stage s holds the sum of rows from stages < s. Its own rows are added
  // combinationally on the way into stage s+1 (or into the output register).
  logic [STAGES-1:0]            vld_q, vld_d;
  logic [STAGES-1:0]            sgn_q, sgn_d;
  logic [STAGES-1:0][WIDTH-1:0] mlr_q, mlr_d;
  logic [STAGES-1:0][WIDTH-1:0] mcd_q, mcd_d;
  logic [STAGES-1:0][PW-1:0]    sum_q, sum_d;
  logic [STAGES-1:0][PW-1:0]    stage_out;
  logic [PW-1:0]                final_prod;
  logic                         adv;
  logic                         done_q, done_d;
  logic [PW-1:0]                product_q, product_d;

  always_comb begin
    for (int s = 0; s < STAGES; s++) begin
      stage_out[s] = sum_q[s] + rows_sum(mlr_q[s], mcd_q[s], sgn_q[s], s * ROWS,
                                         ((s + 1) * ROWS > WIDTH) ? WIDTH : (s + 1) * ROWS);
    end
  end

  assign final_prod = stage_out[STAGES-1];
  assign adv        = ~done_q | ack94;

`ifdef MULT_ACCUM_EN
  logic [STAGES-1:0] clr_q, clr_d;
  logic              ovf_q, ovf_d;
  logic [PW:0]       acc_sum;
  logic              add_ovf;

  always_comb begin
    acc_sum = {1'b0, product_q} + {1'b0, final_prod};
    // Signed overflow: both addends share a sign that the sum does not.
    if (sgn_q[STAGES-1]) begin
      add_ovf = (product_q[PW-1] == final_prod[PW-1]) &&
                (acc_sum[PW-1] != product_q[PW-1]);
    end else begin
      add_ovf = acc_sum[PW];
    end
  end
`endif

  // Pipeline next state: stage 0 takes the ports, the others shift.
  always_comb begin
    vld_d[0] = start94;
    sgn_d[0] = signed94;
    mlr_d[0] = multiplier94;
    mcd_d[0] = multiplicand94;
    sum_d[0] = signed94 ? BW_CONST : '0;
`ifdef MULT_ACCUM_EN
    clr_d[0] = acc_clr94;
`endif
    for (int s = 1; s < STAGES; s++) begin
      vld_d[s] = vld_q[s-1];
      sgn_d[s] = sgn_q[s-1];
      mlr_d[s] = mlr_q[s-1];
      mcd_d[s] = mcd_q[s-1];
      sum_d[s] = stage_out[s-1];
`ifdef MULT_ACCUM_EN
      clr_d[s] = clr_q[s-1];
`endif
    end
  end

  // Output stage: the product changes only when a valid result enters.
  always_comb begin
    done_d    = done_q;
    product_d = product_q;
`ifdef MULT_ACCUM_EN
    ovf_d     = ovf_q;
`endif
    if (adv) begin
      done_d = vld_q[STAGES-1];
      if (vld_q[STAGES-1]) begin
`ifdef MULT_ACCUM_EN
        if (clr_q[STAGES-1]) begin
          product_d = final_prod;
          ovf_d     = 1'b0;
        end else begin
          product_d = acc_sum[PW-1:0];
          ovf_d     = ovf_q | add_ovf;
        end
`else
        product_d = final_prod;
`endif
      end
    end
  end

  always_ff @(posedge clk94) begin
    if (rst94) begin
      vld_q     <= '0;
      done_q    <= 1'b0;
      product_q <= '0;
`ifdef MULT_ACCUM_EN
      ovf_q     <= 1'b0;
`endif
    end else begin
      done_q    <= done_d;
      product_q <= product_d;
`ifdef MULT_ACCUM_EN
      ovf_q     <= ovf_d;
`endif
      if (adv) begin
        vld_q <= vld_d;
        sgn_q <= sgn_d;
        mlr_q <= mlr_d;
        mcd_q <= mcd_d;
        sum_q <= sum_d;
`ifdef MULT_ACCUM_EN
        clr_q <= clr_d;
`endif
      end
    end
  end

  assign ready94   = adv;
  assign done94    = done_q;
  assign product94 = product_q;
`ifdef MULT_ACCUM_EN
  assign overflow94 = ovf_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipelined_array_multiplier.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pipelined_array_multiplier
//  Purpose  : Self-checking bench for pipelined_array_multiplier (WIDTH=16,
//             STAGES=4). Directed scenarios plus a randomized stream that is
//             scored against an integer-arithmetic reference.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pipelined_array_multiplier;

  localparam int W = 16;
  localparam int S = 4;

  logic           clk94 = 1'b0;
  logic           rst94;
  logic           start94;
  logic           signed94;
  logic           ack94;
  logic           ready94;
  logic           done94;
  logic [W-1:0]   multiplier94;
  logic [W-1:0]   multiplicand94;
  logic [2*W-1:0] product94;
`ifdef MULT_ACCUM_EN
  logic           acc_clr94;
  logic           overflow94;
`endif

  int             n_checks = 0;
  int             n_fail   = 0;
  logic [2*W-1:0] exp_q[$];

  always #5 clk94 = ~clk94;

  pipelined_array_multiplier #(.WIDTH(W), .STAGES(S)) dut (
    .clk94          (clk94),
    .rst94          (rst94),
    .start94        (start94),
    .signed94       (signed94),
    .multiplier94   (multiplier94),
    .multiplicand94 (multiplicand94),
`ifdef MULT_ACCUM_EN
    .acc_clr94      (acc_clr94),
    .overflow94     (overflow94),
`endif
    .ready94        (ready94),
    .done94         (done94),
    .ack94          (ack94),
    .product94      (product94)
  );

  // Reference: exact integer product, truncated to 2*W bits.
  function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic sgn);
    longint p;
    if (sgn) p = longint'($signed(a)) * longint'($signed(b));
    else     p = longint'(a) * longint'(b);
    return p[2*W-1:0];
  endfunction

  task automatic tick();
    @(posedge clk94);
    #1;
  endtask

  task automatic drive(input logic st, input logic sg, input logic [W-1:0] a,
                       input logic [W-1:0] b);
    start94        = st;
    signed94       = sg;
    multiplier94   = a;
    multiplicand94 = b;
  endtask

  task automatic test_reset();
    rst94 = 1'b1;
    ack94 = 1'b0;
    drive(1'b1, 1'b0, 16'd3, 16'd3);
`ifdef MULT_ACCUM_EN
    acc_clr94 = 1'b1;
`endif
    tick();
    tick();
    n_checks++;
    if (done94 !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done94); end
    n_checks++;
    if (product94 !== 32'h0) begin n_fail++; $display("FAIL reset_product: got %h expected 0", product94); end
    rst94   = 1'b0;
    start94 = 1'b0;
    #1;
    n_checks++;
    if (ready94 !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b expected 1", ready94); end
  endtask

  task automatic test_unsigned_max();
    int cyc;
    ack94 = 1'b1;
    drive(1'b1, 1'b0, 16'hFFFF, 16'hFFFF);
    tick();
    start94 = 1'b0;
    cyc = 0;
    do begin tick(); cyc++; end while (done94 !== 1'b1 && cyc < 12);
    n_checks++;
    if (cyc != S) begin n_fail++; $display("FAIL umax_latency: got %0d cycles expected %0d", cyc, S); end
    n_checks++;
    if (product94 !== 32'hFFFE0001) begin n_fail++; $display("FAIL umax_product: got %h expected fffe0001", product94); end
    tick();
    n_checks++;
    if (done94 !== 1'b0) begin n_fail++; $display("FAIL umax_done_fall: got %b expected 0", done94); end
    n_checks++;
    if (product94 !== 32'hFFFE0001) begin n_fail++; $display("FAIL umax_hold: got %h expected fffe0001", product94); end
  endtask

  task automatic test_signed_corner();
    int cyc;
    ack94 = 1'b1;
    drive(1'b1, 1'b1, 16'h8000, 16'h8000);
    tick();
    drive(1'b1, 1'b1, 16'hFFFF, 16'h0002);
    tick();
    start94 = 1'b0;
    cyc = 0;
    while (done94 !== 1'b1 && cyc < 12) begin tick(); cyc++; end
    n_checks++;
    if (done94 !== 1'b1 || product94 !== 32'h40000000) begin
      n_fail++; $display("FAIL signed_corner: got done=%b %h expected done=1 40000000", done94, product94);
    end
    tick();
    n_checks++;
    if (done94 !== 1'b1 || product94 !== 32'hFFFFFFFE) begin
      n_fail++; $display("FAIL signed_neg: got done=%b %h expected done=1 fffffffe", done94, product94);
    end
    tick();
    n_checks++;
    if (done94 !== 1'b0) begin n_fail++; $display("FAIL signed_done_fall: got %b expected 0", done94); end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0]   av[3];
    logic [W-1:0]   bv[3];
    logic [2*W-1:0] ev[3];
    int cyc;
    av = '{16'd3, 16'd7, 16'd0};
    bv = '{16'd5, 16'd9, 16'hABCD};
    ev = '{32'd15, 32'd63, 32'd0};
    ack94 = 1'b1;
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 1'b0, av[k], bv[k]);
      tick();
    end
    start94 = 1'b0;
    cyc = 0;
    while (done94 !== 1'b1 && cyc < 12) begin tick(); cyc++; end
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if (done94 !== 1'b1 || product94 !== ev[k]) begin
        n_fail++; $display("FAIL b2b_%0d: got done=%b %0d expected done=1 %0d", k, done94, product94, ev[k]);
      end
      tick();
    end
    n_checks++;
    if (done94 !== 1'b0) begin n_fail++; $display("FAIL b2b_done_fall: got %b expected 0", done94); end
  endtask

  task automatic test_stall();
    int cyc;
    ack94 = 1'b0;
    drive(1'b1, 1'b0, 16'd11, 16'd13);  tick();
    drive(1'b1, 1'b0, 16'd100, 16'd200); tick();
    drive(1'b1, 1'b1, 16'hFFFD, 16'd5); tick();
    start94 = 1'b0;
    cyc = 0;
    while (done94 !== 1'b1 && cyc < 12) begin tick(); cyc++; end
    n_checks++;
    if (done94 !== 1'b1 || product94 !== 32'd143) begin
      n_fail++; $display("FAIL stall_first: got done=%b %0d expected done=1 143", done94, product94);
    end
    // Producer presents a new op during the stall and holds it.
    drive(1'b1, 1'b0, 16'd9, 16'd9);
    for (int k = 0; k < 5; k++) begin
      #1;
      n_checks++;
      if (ready94 !== 1'b0) begin n_fail++; $display("FAIL stall_ready_%0d: got %b expected 0", k, ready94); end
      tick();
      n_checks++;
      if (done94 !== 1'b1 || product94 !== 32'd143) begin
        n_fail++; $display("FAIL stall_hold_%0d: got done=%b %0d expected done=1 143", k, done94, product94);
      end
    end
    ack94 = 1'b1;
    #1;
    n_checks++;
    if (ready94 !== 1'b1) begin n_fail++; $display("FAIL stall_release_ready: got %b expected 1", ready94); end
    exp_q.delete();
    exp_q.push_back(32'd20000);
    exp_q.push_back(32'hFFFFFFF1);
    exp_q.push_back(32'd81);
    tick();
    start94 = 1'b0;
    cyc = 0;
    while (exp_q.size() > 0 && cyc < 20) begin
      if (done94 === 1'b1) begin
        n_checks++;
        if (product94 !== exp_q[0]) begin
          n_fail++; $display("FAIL stall_drain: got %h expected %h", product94, exp_q[0]);
        end
        void'(exp_q.pop_front());
      end
      tick();
      cyc++;
    end
    n_checks++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL stall_lost: %0d results missing expected 0", exp_q.size()); end
  endtask

  task automatic test_reset_flush();
    ack94 = 1'b1;
    drive(1'b1, 1'b0, 16'd6, 16'd7);
    tick();
    start94 = 1'b0;
    tick();
    // Reset wins over a simultaneous start and ack.
    rst94 = 1'b1;
    drive(1'b1, 1'b0, 16'd2, 16'd2);
    tick();
    rst94   = 1'b0;
    start94 = 1'b0;
    n_checks++;
    if (product94 !== 32'h0) begin n_fail++; $display("FAIL flush_product: got %h expected 0", product94); end
    for (int k = 0; k < 8; k++) begin
      tick();
      n_checks++;
      if (done94 !== 1'b0) begin n_fail++; $display("FAIL flush_done_%0d: got %b expected 0", k, done94); end
    end
    n_checks++;
    if (product94 !== 32'h0) begin n_fail++; $display("FAIL flush_product_end: got %h expected 0", product94); end
  endtask

  function automatic logic [W-1:0] pick_operand();
    case ($urandom_range(0, 7))
      0:       return 16'h0000;
      1:       return 16'hFFFF;
      2:       return 16'h8000;
      3:       return 16'h7FFF;
      default: return 16'($urandom_range(0, 65535));
    endcase
  endfunction

  task automatic test_random();
    logic         pend;
    logic [W-1:0] ra, rb;
    logic         rs;
    int           cyc;
    exp_q.delete();
    pend = 1'b0;
    ra = '0; rb = '0; rs = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (!pend && $urandom_range(0, 9) < 6) begin
        ra   = pick_operand();
        rb   = pick_operand();
        rs   = 1'($urandom_range(0, 1));
        pend = 1'b1;
      end
      drive(pend, rs, ra, rb);
      ack94 = ($urandom_range(0, 9) < 7);
      #1;
      n_checks++;
      if (ready94 !== (!done94 || ack94)) begin
        n_fail++; $display("FAIL rand_ready: got %b expected %b", ready94, (!done94 || ack94));
      end
      if (done94 === 1'b1 && ack94) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL rand_spurious: got %h expected no result", product94);
        end else begin
          if (product94 !== exp_q[0]) begin
            n_fail++; $display("FAIL rand_product: got %h expected %h", product94, exp_q[0]);
          end
          void'(exp_q.pop_front());
        end
      end
      if (pend && ready94 === 1'b1) begin
        exp_q.push_back(ref_mul(ra, rb, rs));
        pend = 1'b0;
      end
      tick();
    end
    start94 = 1'b0;
    ack94   = 1'b1;
    cyc = 0;
    while (exp_q.size() > 0 && cyc < 30) begin
      if (done94 === 1'b1) begin
        n_checks++;
        if (product94 !== exp_q[0]) begin
          n_fail++; $display("FAIL rand_drain: got %h expected %h", product94, exp_q[0]);
        end
        void'(exp_q.pop_front());
      end
      tick();
      cyc++;
    end
    n_checks++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL rand_lost: %0d results missing expected 0", exp_q.size()); end
  endtask

`ifdef MULT_ACCUM_EN
  task automatic test_accum();
    logic [W-1:0]   av[7];
    logic [W-1:0]   bv[7];
    logic           sv[7];
    logic           cv[7];
    logic [2*W-1:0] ep[7];
    logic           eo[7];
    logic [2*W-1:0] acc;
    logic           ov;
    logic [2*W-1:0] p;
    longint         wide;
    int             nxt, got, cyc;
    av = '{16'd3, 16'd5, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'd1, 16'd2};
    bv = '{16'd4, 16'd6, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'd1, 16'd2};
    sv = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    cv = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    acc = '0;
    ov  = 1'b0;
    for (int k = 0; k < 7; k++) begin
      p = ref_mul(av[k], bv[k], sv[k]);
      if (cv[k]) begin
        acc = p;
        ov  = 1'b0;
      end else begin
        if (sv[k]) begin
          wide = longint'($signed(acc)) + longint'($signed(p));
          if (wide > 64'sd2147483647 || wide < -64'sd2147483648) ov = 1'b1;
        end else begin
          wide = longint'(acc) + longint'(p);
          if (wide > 64'sd4294967295) ov = 1'b1;
        end
        acc = acc + p;
      end
      ep[k] = acc;
      eo[k] = ov;
    end
    ack94 = 1'b1;
    nxt = 0;
    got = 0;
    cyc = 0;
    while (got < 7 && cyc < 40) begin
      if (nxt < 7) begin
        drive(1'b1, sv[nxt], av[nxt], bv[nxt]);
        acc_clr94 = cv[nxt];
        nxt++;
      end else begin
        start94   = 1'b0;
        acc_clr94 = 1'b1;
      end
      #1;
      if (done94 === 1'b1) begin
        n_checks++;
        if (product94 !== ep[got] || overflow94 !== eo[got]) begin
          n_fail++;
          $display("FAIL accum_%0d: got %h ovf=%b expected %h ovf=%b", got, product94, overflow94, ep[got], eo[got]);
        end
        got++;
      end
      tick();
      cyc++;
    end
    start94   = 1'b0;
    acc_clr94 = 1'b1;
    n_checks++;
    if (got != 7) begin n_fail++; $display("FAIL accum_count: got %0d results expected 7", got); end
  endtask
`endif

  initial begin
    test_reset();
    test_unsigned_max();
    test_signed_corner();
    test_back_to_back();
    test_stall();
    test_reset_flush();
    test_random();
`ifdef MULT_ACCUM_EN
    test_accum();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
